dsc_mul_ctrl: RTL and testbench
===============================

# dsc_mul_ctrl

Operand issue and result-capture controller that sits directly upstream of `dsc_mul` and wraps it for system use. It:
- accepts operand pairs over a valid/ready handshake;
- pulses the multiplier's per-operation reset and holds its enable for the whole serial computation;
- captures `z` after `ov`;
- presents product, cycle count and timeout flag over a second valid/ready handshake.

One operation is in flight at a time.

## Interface
- `WIDTH`, default 10: operand width; product is `2*WIDTH`.
- `CYC_W`, default 22: cycle-counter width; also sets the timeout limit of `2**CYC_W-1` RUN cycles.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`: operand pair valid.
- `in_ready  out  1`: controller can accept a pair.
- `in_a, in_b  in  WIDTH`: operands.
- `mul_rst  out  1`: active-high reset to `dsc_mul`.
- `mul_en  out  1`: enable to `dsc_mul`.
- `mul_a, mul_b  out  WIDTH`: latched operands to `dsc_mul`.
- `mul_z  in  2*WIDTH`: product from `dsc_mul`.
- `mul_ov  in  1`: `dsc_mul` finished flag.
- `out_valid  out  1`: result valid.
- `out_ready  in  1`: consumer accepts result.
- `out_z  out  2*WIDTH`: captured product.
- `out_cycles  out  CYC_W`: number of RUN cycles the operation took.
- `out_err  out  1`: timeout occurred; `out_z` is not meaningful.
- `busy  out  1`: state is not IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, OUT.
- **IDLE**
  - `in_ready=1`, `mul_rst=1`, `mul_en=0`.
  - On `in_valid&&in_ready`: latch `in_a`/`in_b` into `mul_a`/`mul_b`, go to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `mul_rst=1`, `mul_en=0`, cycle counter cleared to 0.
  - Next state is RUN.
- **RUN**
  - `mul_rst=0`, `mul_en=1`; cycle counter increments every cycle, and the cycle `mul_ov` is sampled high is counted.
  - `mul_ov` sampled 1: go to DRAIN.
  - Counter reaches `2**CYC_W-1` with `mul_ov` still 0: set error, go to DRAIN. The counter saturates and never wraps.
  - If both conditions occur on the same edge, `mul_ov` wins and error stays 0.
- **DRAIN** (exactly 1 cycle)
  - `mul_en=0`, `mul_rst=0`; lets `mul_z` settle after `ov`.
  - At the end of the cycle, load `out_z<=mul_z`, `out_cycles<=counter`, `out_err<=error`; go to OUT.
- **OUT**
  - `out_valid=1`; `out_z`, `out_cycles` and `out_err` are stable; `mul_rst=1`.
  - On `out_ready`: go to IDLE; `out_valid` falls the next cycle.
  - `out_ready` held low keeps the state in OUT indefinitely with outputs unchanged.
- `mul_a`/`mul_b` hold the latched operands from the accept edge until the next accept.
- Input changes after accept have no effect.
- `in_ready=0` in every state except IDLE; no operation is accepted while a result is pending.
- **Reset** (async, `rst=0`), effective immediately in any state:
  - state goes to IDLE;
  - `mul_rst=1`, `mul_en=0`, `out_valid=0`, `out_err=0`;
  - `out_z=0`, `out_cycles=0`, `mul_a=mul_b=0`, counter 0;
  - `busy=0`, `in_ready=1` (decoded from IDLE).
- Reset in the middle of RUN abandons the operation; no result is produced.

## Timing
- Accept edge → CLEAR for 1 cycle → first RUN cycle with `mul_en=1` is cycle 2 after accept.
- `ov` sampled in RUN → DRAIN for 1 cycle → `out_valid` rises 2 edges after the `ov` sample edge.
- Total latency from accept to `out_valid` is `out_cycles + 3` clocks.
- `out_ready` high in the first OUT cycle → OUT lasts 1 cycle; the earliest next accept is 1 cycle later, in IDLE.
- All outputs are registered or decoded from registered state.
- No combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `dsc_pkg`:
  - state enum `dsc_ctrl_state_t` with values IDLE, CLEAR, RUN, DRAIN, OUT;
  - default `WIDTH` and `CYC_W` constants, reused by `dsc_mul` users.
- One natural sub-module: `sat_counter` (clear, enable, saturate-at-max, `at_max` flag) for the RUN cycle count.
- `dsc_mul` is not instantiated inside this block; it is connected alongside it at the next level up.

## Test plan
- `a=15, b=15` with real `dsc_mul` → `out_z=225`, `out_err=0`, `out_cycles` nonzero, and `out_valid` exactly `out_cycles+3` clocks after accept.
- `a=1023, b=1023` → `out_z=1046529`, `out_err=0`; `a=0, b=517` → `out_z=0`, `out_err=0`.
- Backpressure: hold `out_ready=0` for 5 cycles in OUT → `out_valid`, `out_z` and `out_cycles` stable; `in_ready=0`; `in_valid` pulses are ignored; the next accept happens only after the OUT handshake.
- Async reset asserted mid-RUN → same cycle `mul_rst=1`, `mul_en=0`, `out_valid=0`; after release `in_ready=1` and a new pair `3×7` gives `out_z=21`.
- Timeout with `CYC_W=4` and a stub that holds `mul_ov=0` → `out_err=1`, `out_cycles=15`, and `out_valid` rises 2 cycles after saturation.
- `mul_ov` rising on the same edge the counter hits max → `out_err=0`, `out_cycles=15`.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared definitions for the dsc multiplier family: controller state encoding
// and default operand / cycle-counter widths.
package dsc_pkg;

  localparam int unsigned DSC_WIDTH = 10;
  localparam int unsigned DSC_CYC_W = 22;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUT
  } dsc_ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that saturates at all-ones and flags it.
module sat_counter #(
  parameter int unsigned W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  always_comb at_max = (cnt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dsc_mul_ctrl.sv
// Operand issue / result capture controller wrapped around a serial dsc_mul:
// one operation in flight, valid/ready on both sides, RUN-cycle timeout.
module dsc_mul_ctrl
  import dsc_pkg::*;
#(
  parameter int unsigned WIDTH = DSC_WIDTH,
  parameter int unsigned CYC_W = DSC_CYC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_rst,
  output logic               mul_en,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_z,
  input  logic               mul_ov,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_z,
  output logic [CYC_W-1:0]   out_cycles,
  output logic               out_err,
  output logic               busy
);

  dsc_ctrl_state_t  state_q, state_d;
  logic [CYC_W-1:0] run_cnt;
  logic             run_at_max;
  logic             cnt_clr, cnt_en;
  logic             err_q;

  always_comb begin
    cnt_clr = (state_q == CLEAR);
    cnt_en  = (state_q == RUN);
  end

  sat_counter #(.W(CYC_W)) u_run_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (run_cnt),
    .at_max (run_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Timeout fires one RUN cycle after the counter saturates, so an ov that
  // rises on the saturating edge is still honoured.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (mul_ov || run_at_max) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mul_rst   = (state_q == IDLE) || (state_q == CLEAR) || (state_q == OUT);
    mul_en    = (state_q == RUN);
    out_valid = (state_q == OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      err_q      <= 1'b0;
      out_z      <= '0;
      out_cycles <= '0;
      out_err    <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (state_q == CLEAR) begin
        err_q <= 1'b0;
      end else if (state_q == RUN && !mul_ov && run_at_max) begin
        err_q <= 1'b1;
      end
      if (state_q == DRAIN) begin
        out_z      <= mul_z;
        out_cycles <= run_cnt;
        out_err    <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Directed bench for dsc_mul_ctrl with a latency-programmable multiplier stub
// and a timeline model of each operation.
module tb_dsc_mul_ctrl;

  localparam int W  = 10;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic            mul_rst, mul_en;
  logic [W-1:0]    mul_a, mul_b;
  logic [2*W-1:0]  mul_z = '0;
  logic            mul_ov = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  out_z;
  logic [CW-1:0]   out_cycles;
  logic            out_err;
  logic            busy;

  dsc_mul_ctrl #(.WIDTH(W), .CYC_W(CW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_rst    (mul_rst),
    .mul_en     (mul_en),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_z      (mul_z),
    .mul_ov     (mul_ov),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_cycles (out_cycles),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier stub: raises ov and the product after cur_lat enabled cycles.
  int cur_lat = 1;
  int st_cnt  = 0;
  always @(posedge clk) begin
    if (mul_rst) begin
      st_cnt <= 0;
      mul_ov <= 1'b0;
      mul_z  <= '0;
    end else if (mul_en && !mul_ov) begin
      st_cnt <= st_cnt + 1;
      if (st_cnt + 1 == cur_lat) begin
        mul_ov <= 1'b1;
        mul_z  <= (2*W)'(mul_a) * (2*W)'(mul_b);
      end
    end
  end

  typedef struct {
    logic [2*W-1:0] z;
    int             cycles;
    bit             err;
    int             acc;
    int             lat_edges;
  } exp_t;

  exp_t expq[$];

  // ov becomes visible after lat stub cycles and is sampled one edge later;
  // the controller waits at most 2**CW RUN cycles (count tops out at 2**CW-1,
  // plus the one cycle spent at the ceiling).
  function automatic int run_edges_f(input int lat);
    int lim = 1 << CW;
    return (lat + 1 < lim) ? lat + 1 : lim;
  endfunction

  bit             active = 0;
  int             cur_acc = 0;
  int             cur_run = 0;
  logic [W-1:0]   model_a = '0;
  logic [W-1:0]   model_b = '0;
  logic           prev_ov = 1'b0;
  logic [2*W-1:0] cap_z = '0;
  int             cap_c = 0;
  bit             cap_e = 0;

  always @(negedge clk) begin
    if (rst) begin
      bit en_exp, rst_exp, ov_exp;
      en_exp  = active && (cyc >= cur_acc + 1) && (cyc <= cur_acc + cur_run);
      rst_exp = !(active && (cyc >= cur_acc + 1) && (cyc <= cur_acc + cur_run + 1));
      ov_exp  = active && (cyc >= cur_acc + cur_run + 2);
      chk("mul_a", mul_a, model_a);
      chk("mul_b", mul_b, model_b);
      chk("in_ready", in_ready, !active);
      chk("busy", busy, active);
      chk("mul_en", mul_en, en_exp);
      chk("mul_rst", mul_rst, rst_exp);
      chk("out_valid", out_valid, ov_exp);
      if (out_valid && !prev_ov) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got out_valid=1 expected no pending op");
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (!e.err) chk("out_z", out_z, e.z);
          chk("out_cycles", out_cycles, e.cycles);
          chk("out_err", out_err, e.err);
          chk("latency", cyc - e.acc + 1, e.lat_edges);
        end
        cap_z = out_z;
        cap_c = int'(out_cycles);
        cap_e = out_err;
      end else if (out_valid) begin
        chk("hold_z", out_z, cap_z);
        chk("hold_cycles", out_cycles, cap_c);
        chk("hold_err", out_err, cap_e);
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic wait_ready();
    @(negedge clk);
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                       input int hold, input logic [2*W-1:0] z_lit, input int cyc_lit,
                       input bit err_lit);
    exp_t e;
    int   run;
    cur_lat = lat;
    wait_ready();
    chk("wait_in_ready", in_ready, 1'b1);
    if (in_ready !== 1'b1) return;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    run = run_edges_f(lat);
    e.z         = z_lit;
    e.err       = (lat + 1 > (1 << CW));
    e.cycles    = (run < (1 << CW)) ? run : (1 << CW) - 1;
    e.acc       = cyc + 1;
    e.lat_edges = run + 3;
    expq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    model_a = a;
    model_b = b;
    active  = 1;
    cur_acc = e.acc;
    cur_run = run;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("wait_out_valid", out_valid, 1'b1);
    // Garbage offers while the result is pending must be ignored.
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    active = 0;
    #1 out_ready = 1'b0;
    chk("lit_cycles", cap_c, cyc_lit);
    chk("lit_err", cap_e, err_lit);
    if (!err_lit) chk("lit_z", cap_z, z_lit);
  endtask

  task automatic reset_mid_run();
    cur_lat = 1000;
    wait_ready();
    in_valid = 1'b1;
    in_a = 10'd9;
    in_b = 10'd9;
    cur_acc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_a = 10'd9;
    model_b = 10'd9;
    cur_run = run_edges_f(1000);
    active  = 1;
    repeat (4) @(negedge clk);
    chk("pre_reset_mul_en", mul_en, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mul_rst", mul_rst, 1'b1);
    chk("arst_mul_en", mul_en, 1'b0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_z", out_z, 0);
    chk("arst_out_cycles", out_cycles, 0);
    chk("arst_out_err", out_err, 1'b0);
    chk("arst_mul_a", mul_a, 0);
    chk("arst_mul_b", mul_b, 0);
    active  = 0;
    model_a = '0;
    model_b = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mul_rst", mul_rst, 1'b1);
    chk("rst_mul_en", mul_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_mul_a", mul_a, 0);
    @(negedge clk);
    rst = 1'b1;
    //     a     b     lat   hold z         cycles err
    do_op(15,   15,   6,    0,   225,      7,     0);
    do_op(1023, 1023, 10,   0,   1046529,  11,    0);
    do_op(0,    517,  3,    5,   0,        4,     0);
    do_op(100,  200,  1,    2,   20000,    2,     0);
    do_op(2,    3,    14,   0,   6,        15,    0);
    do_op(12,   12,   15,   0,   144,      15,    0);
    do_op(5,    9,    1000, 1,   45,       15,    1);
    reset_mid_run();
    do_op(3,    7,    2,    0,   21,       3,     0);
    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
